// File: rtl/dms_pkg.sv
// dms_pkg: shared DMS types and default constants for the phase-frequency detector and charge pump.
package dms_pkg;

    typedef enum logic [1:0] {IDLE, UP, DN, BOTH} pfd_state_t;

    localparam int DMS_PFD_DZ_CYCLES = 2;
    localparam int DMS_PFD_ERR_W     = 8;

endpackage

// File: rtl/dms_pfd_if.sv
// dms_pfd_if: detector clocks/enable in, charge-pump controls and phase-error report out.
interface dms_pfd_if import dms_pkg::*; #(
    parameter int ERR_W = DMS_PFD_ERR_W
);
    logic             ref_clk;
    logic             fb_clk;
    logic             en;
    logic             up;
    logic             down;
    logic [ERR_W-1:0] err_mag;
    logic             err_sign;
    logic             err_valid;
    logic             lock;

    modport master (
        output ref_clk, fb_clk, en,
        input  up, down, err_mag, err_sign, err_valid, lock
    );

    modport slave (
        input  ref_clk, fb_clk, en,
        output up, down, err_mag, err_sign, err_valid, lock
    );
endinterface

// File: rtl/dms_sync_edge.sv
// dms_sync_edge: synchronizes an asynchronous clock into clk and flags its rising edges.
module dms_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

// File: rtl/dms_pfd.sv
// dms_pfd: clocked tri-state PFD with anti-dead-zone overlap and phase-error measurement.
// Define DMS_PFD_LOCK_DET_EN to build the lock detector; otherwise lock is tied low.
module dms_pfd import dms_pkg::*; #(
    parameter int SYNC_STAGES = 2,
    parameter int DZ_CYCLES   = DMS_PFD_DZ_CYCLES,
    parameter int ERR_W       = DMS_PFD_ERR_W,
    parameter int LOCK_TOL    = 2,
    parameter int LOCK_COUNT  = 16
) (
    input logic      clk,
    input logic      rst_n,
    dms_pfd_if.slave pfd
);
    localparam int               DW      = $clog2(DZ_CYCLES + 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    if (SYNC_STAGES < 2 || DZ_CYCLES < 1 || ERR_W < 1 || LOCK_TOL < 0 || LOCK_COUNT < 1) begin : g_bad_param
        $error("dms_pfd: invalid parameter");
    end

    logic             ref_rise, fb_rise;
    pfd_state_t       state_q, state_d;
    logic [ERR_W-1:0] cnt_q, cnt_d, cnt_inc, err_mag_q, err_mag_d;
    logic [DW-1:0]    dz_q, dz_d;
    logic             err_sign_q, err_sign_d, err_valid_q, err_valid_d, up_q, down_q;

    dms_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ref (.clk(clk), .rst_n(rst_n), .d(pfd.ref_clk), .rise(ref_rise));
    dms_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_fb  (.clk(clk), .rst_n(rst_n), .d(pfd.fb_clk),  .rise(fb_rise));

    // err_mag includes the cycle on which the lagging edge arrives
    always_comb begin
        cnt_inc     = (cnt_q == ERR_MAX) ? cnt_q : cnt_q + 1'b1;
        state_d     = state_q;
        cnt_d       = cnt_q;
        dz_d        = dz_q;
        err_mag_d   = err_mag_q;
        err_sign_d  = err_sign_q;
        err_valid_d = 1'b0;
        if (!pfd.en) begin
            state_d = IDLE;
            cnt_d   = '0;
            dz_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    dz_d  = '0;
                    state_d = (ref_rise & fb_rise) ? BOTH : ref_rise ? UP : fb_rise ? DN : IDLE;
                    if (ref_rise & fb_rise) begin
                        err_mag_d   = '0;
                        err_sign_d  = 1'b0;
                        err_valid_d = 1'b1;
                    end
                end
                UP, DN: begin
                    cnt_d = cnt_inc;
                    if ((state_q == UP) ? fb_rise : ref_rise) begin
                        state_d     = BOTH;
                        cnt_d       = '0;
                        dz_d        = '0;
                        err_mag_d   = cnt_inc;
                        err_sign_d  = (state_q == UP);
                        err_valid_d = 1'b1;
                    end
                end
                BOTH: begin
                    state_d = (dz_q == DW'(DZ_CYCLES - 1)) ? IDLE : BOTH;
                    dz_d    = (dz_q == DW'(DZ_CYCLES - 1)) ? '0 : dz_q + 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dz_q        <= '0;
            err_mag_q   <= '0;
            err_sign_q  <= 1'b0;
            err_valid_q <= 1'b0;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dz_q        <= dz_d;
            err_mag_q   <= err_mag_d;
            err_sign_q  <= err_sign_d;
            err_valid_q <= err_valid_d;
            up_q        <= (state_d == UP) || (state_d == BOTH);
            down_q      <= (state_d == DN) || (state_d == BOTH);
        end
    end

    assign pfd.up        = up_q;
    assign pfd.down      = down_q;
    assign pfd.err_mag   = err_mag_q;
    assign pfd.err_sign  = err_sign_q;
    assign pfd.err_valid = err_valid_q;

`ifdef DMS_PFD_LOCK_DET_EN
    localparam int LW = $clog2(LOCK_COUNT + 1);

    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
    logic          lock_q;

    // counted on the same edge that raises err_valid, so lock follows one cycle later
    assign lock_cnt_d = !pfd.en ? '0 :
                        !err_valid_d ? lock_cnt_q :
                        (err_mag_d > ERR_W'(LOCK_TOL)) ? '0 :
                        (lock_cnt_q == LW'(LOCK_COUNT)) ? lock_cnt_q : lock_cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt_q <= '0;
            lock_q     <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            lock_q     <= pfd.en && (lock_cnt_q == LW'(LOCK_COUNT));
        end
    end

    assign pfd.lock = lock_q;
`else
    assign pfd.lock = 1'b0;
`endif
endmodule

// File: tb/tb_dms_pfd.sv
// tb_dms_pfd: directed-vector bench for dms_pfd with hand-computed expectations.
module tb_dms_pfd;
    logic clk, rst_n;
    int   n_chk, n_err;
    int   n_up, n_dn, n_both, n_val, first_up, first_dn;
    logic [7:0] mag;
    logic sgn, v_lock, n_lock, pv;

    dms_pfd_if #(.ERR_W(8)) pfd ();

    dms_pfd #(
        .SYNC_STAGES(2), .DZ_CYCLES(2), .ERR_W(8), .LOCK_TOL(2), .LOCK_COUNT(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pfd(pfd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // drive ref/fb per cycle from bit vectors and tally what the detector does
    task automatic run(input logic [63:0] rw, input logic [63:0] fw, input int n);
        n_up = 0; n_dn = 0; n_both = 0; n_val = 0;
        first_up = -1; first_dn = -1;
        v_lock = 0; n_lock = 0; pv = 0;
        for (int i = 0; i < n; i++) begin
            pfd.ref_clk = rw[i];
            pfd.fb_clk  = fw[i];
            step();
            if (pv) n_lock = pfd.lock;
            pv = pfd.err_valid;
            if (pfd.up && !pfd.down) n_up++;
            if (pfd.down && !pfd.up) n_dn++;
            if (pfd.up && pfd.down) n_both++;
            if (pfd.up && first_up < 0) first_up = i;
            if (pfd.down && first_dn < 0) first_dn = i;
            if (pfd.err_valid) begin
                n_val++;
                mag    = pfd.err_mag;
                sgn    = pfd.err_sign;
                v_lock = pfd.lock;
            end
        end
    endtask

    initial begin
        int   bad, nv;
        logic got;
        n_chk = 0; n_err = 0;
        rst_n = 1'b0; pfd.en = 1'b0; pfd.ref_clk = 1'b0; pfd.fb_clk = 1'b0;
        repeat (3) step();
        check("reset_outputs", {pfd.up, pfd.down, pfd.err_valid, pfd.err_sign, pfd.lock, pfd.err_mag}, 0);
        rst_n = 1'b1;
        pfd.en = 1'b1;
        step();

        // asynchronous reset while up is asserted
        pfd.ref_clk = 1'b1;
        repeat (3) step();
        check("rst_pre_up", pfd.up, 1);
        #2 rst_n = 1'b0;
        #1 check("rst_async_outputs", {pfd.up, pfd.down, pfd.err_valid, pfd.lock, pfd.err_mag}, 0);
        pfd.ref_clk = 1'b0;
        #2 rst_n = 1'b1;
        repeat (4) step();
        check("rst_idle_after", {pfd.up, pfd.down}, 0);

        // ref leads fb by 10 cycles
        run(64'h3F, 64'h3F << 10, 30);
        check("ref_lead_latency", first_up, 2);
        check("ref_lead_up_only", n_up, 10);
        check("ref_lead_overlap", n_both, 2);
        check("ref_lead_down_only", n_dn, 0);
        check("ref_lead_valid", n_val, 1);
        check("ref_lead_mag", mag, 10);
        check("ref_lead_sign", sgn, 1);

        // fb leads ref by 5 cycles
        run(64'h20, 64'h1, 20);
        check("fb_lead_latency", first_dn, 2);
        check("fb_lead_down_only", n_dn, 5);
        check("fb_lead_overlap", n_both, 2);
        check("fb_lead_up_only", n_up, 0);
        check("fb_lead_mag", mag, 5);
        check("fb_lead_sign", sgn, 0);

        // simultaneous edges, then a ref edge landing on the BOTH exit cycle
        run(64'b101, 64'b1, 16);
        check("simul_overlap", n_both, 2);
        check("simul_up_only", n_up, 0);
        check("simul_valid", n_val, 1);
        check("simul_mag", mag, 0);

        // fb stuck low while ref keeps toggling: counter saturates
        bad = 0; nv = 0;
        for (int i = 0; i < 300; i++) begin
            pfd.ref_clk = ((i / 4) % 2 == 0);
            step();
            if (i >= 2 && !pfd.up) bad++;
            if (pfd.err_valid) nv++;
        end
        check("sat_up_held", bad, 0);
        check("sat_no_valid", nv, 0);
        pfd.ref_clk = 1'b0;
        pfd.fb_clk  = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            step();
            got = pfd.err_valid;
        end
        check("sat_valid_seen", got, 1);
        check("sat_mag", pfd.err_mag, 255);
        check("sat_sign", pfd.err_sign, 1);
        pfd.fb_clk = 1'b0;
        repeat (6) step();

        // disable mid-UP: outputs drop, error report holds, no false edge on re-enable
        pfd.ref_clk = 1'b1;
        repeat (3) step();
        check("en_pre_up", pfd.up, 1);
        pfd.en = 1'b0;
        step();
        check("en_off_outputs", {pfd.up, pfd.down, pfd.err_valid}, 0);
        check("en_off_mag_hold", pfd.err_mag, 255);
        check("en_off_sign_hold", pfd.err_sign, 1);
        pfd.en = 1'b1;
        bad = 0;
        repeat (5) begin
            step();
            if (pfd.up || pfd.down) bad++;
        end
        check("en_no_false_edge", bad, 0);
        pfd.ref_clk = 1'b0;
        repeat (4) step();

        // sixteen in-tolerance comparisons, then one out of tolerance
        for (int k = 1; k <= 16; k++) begin
            run(64'h1, 64'h2, 10);
            if (k == 1) check("lock_cmp_mag", mag, 1);
            if (k == 15) check("lock_after_15", n_lock, 0);
            if (k == 16) check("lock_at_16th_valid", v_lock, 0);
        end
`ifdef DMS_PFD_LOCK_DET_EN
        check("lock_after_16", n_lock, 1);
        run(64'h1, 64'h20, 16);
        check("lock_bad_mag", mag, 5);
        check("lock_at_bad_valid", v_lock, 1);
        check("lock_drop", n_lock, 0);
`else
        check("lock_tied_low", n_lock, 0);
        check("lock_tied_low_now", pfd.lock, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
